// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter_pkg
// Purpose  : Shared AXI constants, field widths and arbiter FSM encoding
// Revision : 1.0 - initial release
// ============================================================================
package axi_rd_arbiter_pkg;

    // AXI burst / response encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // AXI field widths that do not depend on the bus parameters
    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;

    // Arbiter FSM: choose a master, pass its AR, then stream its R beats
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-input round-robin picker. A lone requester wins; when both
//            request, the one that did not win last time is chosen.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       any
);

    // Pure combinational pick; the caller registers the result
    always_comb begin
        any   = |req;
        grant = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : 2:1 AXI4 read-channel arbiter (IFU = master 0, LSU = master 1)
//            in front of a single pmem slave. One master owns the bus from
//            its AR handshake through the RLAST beat; beat count is checked
//            against the captured ARLEN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    // master 0 (IFU)
    input  logic               m0_arvalid,
    input  logic [ADDR_W-1:0]  m0_araddr,
    input  logic [ID_W-1:0]    m0_arid,
    input  logic [LEN_W-1:0]   m0_arlen,
    input  logic [SIZE_W-1:0]  m0_arsize,
    input  logic [BURST_W-1:0] m0_arburst,
    output logic               m0_arready,
    input  logic               m0_rready,
    output logic               m0_rvalid,
    output logic [DATA_W-1:0]  m0_rdata,
    output logic [RESP_W-1:0]  m0_rresp,
    output logic               m0_rlast,
    output logic [ID_W-1:0]    m0_rid,
    // master 1 (LSU read port)
    input  logic               m1_arvalid,
    input  logic [ADDR_W-1:0]  m1_araddr,
    input  logic [ID_W-1:0]    m1_arid,
    input  logic [LEN_W-1:0]   m1_arlen,
    input  logic [SIZE_W-1:0]  m1_arsize,
    input  logic [BURST_W-1:0] m1_arburst,
    output logic               m1_arready,
    input  logic               m1_rready,
    output logic               m1_rvalid,
    output logic [DATA_W-1:0]  m1_rdata,
    output logic [RESP_W-1:0]  m1_rresp,
    output logic               m1_rlast,
    output logic [ID_W-1:0]    m1_rid,
    // slave (pmem)
    output logic               s_arvalid,
    output logic [ADDR_W-1:0]  s_araddr,
    output logic [ID_W-1:0]    s_arid,
    output logic [LEN_W-1:0]   s_arlen,
    output logic [SIZE_W-1:0]  s_arsize,
    output logic [BURST_W-1:0] s_arburst,
    input  logic               s_arready,
    input  logic               s_rvalid,
    input  logic [DATA_W-1:0]  s_rdata,
    input  logic [RESP_W-1:0]  s_rresp,
    input  logic               s_rlast,
    input  logic [ID_W-1:0]    s_rid,
    output logic               s_rready,
    output logic               err_beats
);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic             r_grant;
    logic             r_last_grant;
    logic             r_err_beats;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_beat_cnt;
    logic             w_pick_grant;
    logic             w_pick_any;
    logic             w_ar_hs;
    logic             w_r_hs;

    rr_pick2 u_pick (
        .req        ({m1_arvalid, m0_arvalid}),
        .last_grant (r_last_grant),
        .grant      (w_pick_grant),
        .any        (w_pick_any)
    );

    assign w_ar_hs   = (r_state == ADDR) && s_arvalid && s_arready;
    assign w_r_hs    = (r_state == DATA) && s_rvalid && s_rready;
    assign err_beats = r_err_beats;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: leave DATA only on the RLAST beat, never re-arbitrate in ADDR
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_next_state = ADDR;
            ADDR:    if (w_ar_hs) w_next_state = DATA;
            DATA:    if (w_r_hs && s_rlast) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Grant, burst length capture, beat counting and the sticky beat-count error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_len_q      <= '0;
            r_beat_cnt   <= '0;
            r_err_beats  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_pick_any) begin
                r_grant <= w_pick_grant;
            end
            if (w_ar_hs) begin
                r_len_q    <= s_arlen;
                r_beat_cnt <= '0;
            end
            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (s_rlast) begin
                    if (r_beat_cnt != r_len_q) begin
                        r_err_beats <= 1'b1;
                    end
                    r_last_grant <= r_grant;
                end else if (r_beat_cnt == r_len_q) begin
                    r_err_beats <= 1'b1;
                end
            end
        end
    end

    // Channel muxing: AR of the granted master in ADDR, R to the granted master in DATA
    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_arid     = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rlast   = 1'b0;
        m0_rid     = '0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rlast   = 1'b0;
        m1_rid     = '0;
        if (r_state == ADDR) begin
            if (!r_grant) begin
                s_arvalid  = m0_arvalid;
                s_araddr   = m0_araddr;
                s_arid     = m0_arid;
                s_arlen    = m0_arlen;
                s_arsize   = m0_arsize;
                s_arburst  = m0_arburst;
                m0_arready = s_arready;
            end else begin
                s_arvalid  = m1_arvalid;
                s_araddr   = m1_araddr;
                s_arid     = m1_arid;
                s_arlen    = m1_arlen;
                s_arsize   = m1_arsize;
                s_arburst  = m1_arburst;
                m1_arready = s_arready;
            end
        end else if (r_state == DATA) begin
            if (!r_grant) begin
                m0_rvalid = s_rvalid;
                m0_rdata  = s_rdata;
                m0_rresp  = s_rresp;
                m0_rlast  = s_rlast;
                m0_rid    = s_rid;
                s_rready  = m0_rready;
            end else begin
                m1_rvalid = s_rvalid;
                m1_rdata  = s_rdata;
                m1_rresp  = s_rresp;
                m1_rlast  = s_rlast;
                m1_rid    = s_rid;
                s_rready  = m1_rready;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Directed self-checking bench for axi_rd_arbiter with a simple
//            pmem responder (data word = address of the beat).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [31:0] m0_araddr, m1_araddr;
    logic [3:0]  m0_arid, m1_arid;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst;
    logic        m0_rready, m1_rready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [3:0]  m0_rid, m1_rid;
    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready, err_beats;
    logic [31:0] s_araddr, s_rdata;
    logic [3:0]  s_arid, s_rid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;

    int n_tests = 0;
    int n_fail  = 0;
    int inj_last = -1;

    logic [31:0] q0_data[$], q1_data[$];
    logic        q0_last[$], q1_last[$];
    logic [3:0]  ar_order[$];
    int          m1_rv_cnt = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready), .m0_rready(m0_rready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready), .m1_rready(m1_rready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rready(s_rready), .err_beats(err_beats)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pmem responder: accepts every AR, returns len+1 beats (or stops early at inj_last)
    initial begin : g_slave
        logic        ar_hs, r_hs;
        logic [31:0] a_addr, sl_addr;
        logic [7:0]  a_len, sl_len;
        logic [3:0]  a_id, sl_id;
        logic        sl_busy;
        int          sl_beat;
        sl_busy = 1'b0; sl_addr = '0; sl_len = '0; sl_id = '0; sl_beat = 0;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = RESP_OKAY; s_rlast = 1'b0; s_rid = '0;
        forever begin
            @(posedge clk);
            ar_hs  = s_arvalid && s_arready;
            r_hs   = s_rvalid && s_rready;
            a_addr = s_araddr; a_len = s_arlen; a_id = s_arid;
            if (ar_hs) ar_order.push_back(s_arid);
            #1;
            if (reset) begin
                sl_busy = 1'b0;
            end else begin
                if (r_hs) begin
                    if (s_rlast) sl_busy = 1'b0;
                    else sl_beat++;
                end
                if (ar_hs) begin
                    sl_busy = 1'b1; sl_addr = a_addr; sl_len = a_len; sl_id = a_id; sl_beat = 0;
                end
            end
            s_rvalid = sl_busy;
            s_rdata  = sl_addr + 32'(sl_beat) * 32'd4;
            s_rlast  = sl_busy && ((sl_beat == int'(sl_len)) || (sl_beat == inj_last));
            s_rid    = sl_id;
        end
    end

    // Beat monitor on the master side
    always @(posedge clk) begin
        if (m0_rvalid && m0_rready) begin q0_data.push_back(m0_rdata); q0_last.push_back(m0_rlast); end
        if (m1_rvalid && m1_rready) begin q1_data.push_back(m1_rdata); q1_last.push_back(m1_rlast); end
        if (m1_rvalid) m1_rv_cnt++;
    end

    task automatic clear_q();
        q0_data.delete(); q0_last.delete(); q1_data.delete(); q1_last.delete(); ar_order.delete();
    endtask

    // Present one AR on master m and hold it until accepted
    task automatic issue(input bit m, input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        bit done = 1'b0;
        if (!m) begin
            m0_araddr = addr; m0_arlen = len; m0_arid = id; m0_arsize = 3'd2; m0_arburst = BURST_INCR; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = addr; m1_arlen = len; m1_arid = id; m1_arsize = 3'd2; m1_arburst = BURST_INCR; m1_arvalid = 1'b1;
        end
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            done = m ? (m1_arvalid && m1_arready) : (m0_arvalid && m0_arready);
        end
        #1;
        if (!m) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        if (!done) chk("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_q(input bit m, input int n);
        int c = 0;
        while (((m ? q1_data.size() : q0_data.size()) < n) && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) chk("beat_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : g_main
        logic [3:0] pat;
        int c;
        pat = 4'b1001;
        reset = 1'b1;
        m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0; m0_rready = 1;
        m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0; m1_rready = 1;

        // Reset state
        @(negedge clk);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_m1_arready", m1_arready, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_err", err_beats, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single IFU read, len=3; s_arvalid appears one cycle after arvalid
        clear_q();
        @(posedge clk); #1;
        m0_araddr = 32'h8000_0000; m0_arlen = 8'd3; m0_arid = 4'd1; m0_arsize = 3'd2; m0_arburst = BURST_INCR;
        m0_arvalid = 1'b1;
        c = m1_rv_cnt;
        @(negedge clk);
        chk("t1_s_arvalid_idle", s_arvalid, 0);
        @(negedge clk);
        chk("t1_s_arvalid", s_arvalid, 1);
        chk("t1_s_araddr", s_araddr, 32'h8000_0000);
        chk("t1_s_arlen", s_arlen, 8'd3);
        @(posedge clk); #1 m0_arvalid = 1'b0;
        wait_q(0, 4);
        chk("t1_beats", q0_data.size(), 4);
        for (int i = 0; i < q0_data.size() && i < 4; i++) begin
            chk("t1_data", q0_data[i], 32'h8000_0000 + 32'(i) * 4);
            chk("t1_last", q0_last[i], (i == 3) ? 1 : 0);
        end
        chk("t1_m1_rvalid_quiet", m1_rv_cnt - c, 0);
        chk("t1_err", err_beats, 0);

        // Simultaneous requests right after reset: master 0 first
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_q();
        fork
            issue(0, 32'h8000_0010, 8'd0, 4'd1);
            issue(1, 32'h8000_0020, 8'd1, 4'd2);
        join
        wait_q(1, 2);
        chk("t2_order_n", ar_order.size(), 2);
        if (ar_order.size() >= 2) begin
            chk("t2_first", ar_order[0], 4'd1);
            chk("t2_second", ar_order[1], 4'd2);
        end
        chk("t2_m0_beats", q0_data.size(), 1);
        chk("t2_m1_beats", q1_data.size(), 2);
        if (q1_data.size() >= 2) begin
            chk("t2_m1_d1", q1_data[1], 32'h8000_0024);
            chk("t2_m1_last", {q1_last[0], q1_last[1]}, 2'b01);
        end

        // Lone m0 read leaves last_grant=0, so the next pair starts with m1 and alternates
        clear_q();
        issue(0, 32'h8000_0030, 8'd0, 4'd1);
        wait_q(0, 1);
        clear_q();
        fork
            begin issue(0, 32'h8000_0040, 8'd0, 4'd1); issue(0, 32'h8000_0044, 8'd0, 4'd1); end
            begin issue(1, 32'h8000_0050, 8'd0, 4'd2); issue(1, 32'h8000_0054, 8'd0, 4'd2); end
        join
        wait_q(0, 2);
        chk("t2b_order_n", ar_order.size(), 4);
        if (ar_order.size() >= 4)
            chk("t2b_order", {ar_order[0], ar_order[1], ar_order[2], ar_order[3]}, 16'h2121);

        // Backpressure on m1: rready 1,0,0,1 repeating
        clear_q();
        issue(1, 32'h8000_0100, 8'd3, 4'd2);
        for (int k = 0; k < 40 && q1_data.size() < 4; k++) begin
            m1_rready = pat[3 - (k % 4)];
            @(negedge clk);
            chk("t3_s_rready", s_rready, m1_rready);
            @(posedge clk); #1;
        end
        m1_rready = 1'b1;
        wait_q(1, 4);
        chk("t3_beats", q1_data.size(), 4);
        for (int i = 0; i < q1_data.size() && i < 4; i++)
            chk("t3_data", q1_data[i], 32'h8000_0100 + 32'(i) * 4);

        // m1 request during an m0 len=7 burst waits for RLAST, then one IDLE cycle
        clear_q();
        issue(0, 32'h8000_0200, 8'd7, 4'd1);
        c = 0;
        while (q0_data.size() < 2 && c < 100) begin @(negedge clk); c++; end
        @(posedge clk); #1;
        m1_araddr = 32'h8000_0300; m1_arlen = 8'd0; m1_arid = 4'd2; m1_arsize = 3'd2; m1_arburst = BURST_INCR;
        m1_arvalid = 1'b1;
        for (int k = 0; k < 40 && q0_data.size() < 8; k++) begin
            @(negedge clk);
            if (q0_data.size() < 8) begin
                chk("t4_m1_arready_held", m1_arready, 0);
                chk("t4_s_arvalid_held", s_arvalid, 0);
            end
        end
        chk("t4_m0_beats", q0_data.size(), 8);
        chk("t4_idle_s_arvalid", s_arvalid, 0);
        @(negedge clk);
        chk("t4_s_arvalid", s_arvalid, 1);
        chk("t4_s_arid", s_arid, 4'd2);
        chk("t4_m1_arready", m1_arready, 1);
        @(posedge clk); #1 m1_arvalid = 1'b0;
        wait_q(1, 1);
        chk("t4_m1_beats", q1_data.size(), 1);

        // Early RLAST on beat index 2 for len=3 sets the sticky error
        clear_q();
        inj_last = 2;
        issue(0, 32'h8000_0400, 8'd3, 4'd1);
        wait_q(0, 3);
        inj_last = -1;
        chk("t5_beats", q0_data.size(), 3);
        if (q0_data.size() >= 3) chk("t5_last", q0_last[2], 1);
        chk("t5_err", err_beats, 1);
        chk("t5_idle_rvalid", m0_rvalid, 0);
        clear_q();
        issue(0, 32'h8000_0500, 8'd1, 4'd1);
        wait_q(0, 2);
        chk("t5_good_beats", q0_data.size(), 2);
        chk("t5_err_sticky", err_beats, 1);

        // Reset mid-burst: outputs drop immediately, m0 priority restored
        clear_q();
        issue(0, 32'h8000_0600, 8'd3, 4'd1);
        c = 0;
        while (q0_data.size() < 1 && c < 100) begin @(negedge clk); c++; end
        reset = 1'b1;
        #1;
        chk("t6_m0_rvalid", m0_rvalid, 0);
        chk("t6_m0_rlast", m0_rlast, 0);
        chk("t6_s_rready", s_rready, 0);
        chk("t6_s_arvalid", s_arvalid, 0);
        chk("t6_arready", {m0_arready, m1_arready}, 2'b00);
        chk("t6_err_cleared", err_beats, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_q();
        fork
            issue(0, 32'h8000_0700, 8'd1, 4'd1);
            issue(1, 32'h8000_0800, 8'd0, 4'd2);
        join
        wait_q(1, 1);
        chk("t6_order_n", ar_order.size(), 2);
        if (ar_order.size() >= 2) chk("t6_first", ar_order[0], 4'd1);
        chk("t6_m0_beats", q0_data.size(), 2);
        if (q0_data.size() >= 2) begin
            chk("t6_m0_d1", q0_data[1], 32'h8000_0704);
            chk("t6_m0_last", q0_last[1], 1);
        end
        chk("t6_err", err_beats, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
